// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice.
// Contents:
//   OP_*     : 2-bit function-select encodings {S1,S0}
//   state_t  : sequencer FSM states (IDLE, RUN, DONE)
package alu_pkg;

  localparam logic [1:0] OP_CONST = 2'b00;
  localparam logic [1:0] OP_AND   = 2'b01;
  localparam logic [1:0] OP_NOTX  = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit, four-output ALU slice.
// Ports:
//   op      in  2  function select {S1,S0}
//   a, b    in  1  operand bits
//   f1..f4  out 1  slice results for the selected function
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       f1,
  output logic       f2,
  output logic       f3,
  output logic       f4
);

  // Four-output function table selected by op.
  always_comb begin
    f1 = 1'b0;
    f2 = 1'b0;
    f3 = 1'b0;
    f4 = 1'b0;
    case (op)
      OP_CONST: begin
        f1 = 1'b0;
        f2 = 1'b1;
        f3 = a;
        f4 = b;
      end
      OP_AND: begin
        f1 = a & b;
        f2 = a & ~b;
        f3 = ~a & b;
        f4 = ~a & ~b;
      end
      OP_NOTX: begin
        f1 = ~a;
        f2 = ~b;
        f3 = a ^ b;
        f4 = ~(a ^ b);
      end
      OP_OR: begin
        f1 = a | b;
        f2 = a | ~b;
        f3 = ~a | b;
        f4 = ~a | ~b;
      end
      default: begin
        f1 = 1'b0;
        f2 = 1'b0;
        f3 = 1'b0;
        f4 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer: accepts (A, B, op) on a valid/ready request port,
// pushes the operands LSB-first through one alu_bit_slice, one bit per clock,
// and presents the assembled WIDTH-bit words F1..F4 on a valid/ready
// response port.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_a, req_b, req_op payload
//   rsp_valid/rsp_ready   response handshake; rsp_f1..rsp_f4 payload
//   busy                  high while a request is in RUN or DONE
module alu_serial_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f1,
  output logic [WIDTH-1:0] rsp_f2,
  output logic [WIDTH-1:0] rsp_f3,
  output logic [WIDTH-1:0] rsp_f4,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [1:0]       op_r;
  logic             f1_s;
  logic             f2_s;
  logic             f3_s;
  logic             f4_s;

  // Insert a new bit at the MSB and drop the LSB; written as a slice of
  // the widened word so WIDTH=1 needs no special case.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             msb);
    logic [WIDTH:0] tmp;
    tmp = {msb, cur};
    return tmp[WIDTH:1];
  endfunction

  alu_bit_slice u_slice (
    .op (op_r),
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .f1 (f1_s),
    .f2 (f2_s),
    .f3 (f3_s),
    .f4 (f4_s)
  );

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_nxt_s = ST_RUN;
        else           state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (rsp_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Handshake/status outputs, registered from the next state so they
  // always match the state register without any input-to-output path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      req_ready <= (state_nxt_s == ST_IDLE);
      rsp_valid <= (state_nxt_s == ST_DONE);
      busy      <= (state_nxt_s != ST_IDLE);
    end
  end

  // Operand capture, serial stepping and result assembly. Results are
  // touched only in RUN, so they hold their value through IDLE and DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      a_sh_r <= {WIDTH{1'b0}};
      b_sh_r <= {WIDTH{1'b0}};
      op_r   <= 2'b00;
      rsp_f1 <= {WIDTH{1'b0}};
      rsp_f2 <= {WIDTH{1'b0}};
      rsp_f3 <= {WIDTH{1'b0}};
      rsp_f4 <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            a_sh_r <= req_a;
            b_sh_r <= req_b;
            op_r   <= req_op;
            cnt_r  <= {CW{1'b0}};
          end else begin
            cnt_r  <= cnt_r;
          end
        end
        ST_RUN: begin
          rsp_f1 <= shift_in(rsp_f1, f1_s);
          rsp_f2 <= shift_in(rsp_f2, f2_s);
          rsp_f3 <= shift_in(rsp_f3, f3_s);
          rsp_f4 <= shift_in(rsp_f4, f4_s);
          a_sh_r <= a_sh_r >> 1;
          b_sh_r <= b_sh_r >> 1;
          // Saturate at the last index so the counter never wraps.
          if (cnt_r != LAST_CNT) cnt_r <= cnt_r + CW'(1);
          else                   cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer (WIDTH=8): directed vectors,
// response stall, mid-run reset, back-to-back traffic and randomized
// requests checked against a word-level reference model.
module tb_alu_serial_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [1:0]   req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_f1, rsp_f2, rsp_f3, rsp_f4;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f1    (rsp_f1),
    .rsp_f2    (rsp_f2),
    .rsp_f3    (rsp_f3),
    .rsp_f4    (rsp_f4),
    .busy      (busy)
  );

  // Word-level reference: {F1,F2,F3,F4} for whole operands.
  function automatic logic [4*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [1:0]   op);
    case (op)
      2'b00:   return {{W{1'b0}}, {W{1'b1}}, a, b};
      2'b01:   return {a & b, a & ~b, ~a & b, ~a & ~b};
      2'b10:   return {~a, ~b, a ^ b, ~(a ^ b)};
      default: return {a | b, a | ~b, ~a | b, ~a | ~b};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE for one edge, then scramble the request bus
  // to show later changes are ignored.
  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_a  = W'($urandom);
    req_b  = W'($urandom);
    req_op = 2'($urandom);
  endtask

  // Count edges until rsp_valid, bounded.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({rsp_f1, rsp_f2, rsp_f3, rsp_f4} !== {4*W{1'b0}}) begin
      tests_failed++;
      $display("FAIL reset_f: got %h expected 0", {rsp_f1, rsp_f2, rsp_f3, rsp_f4});
    end
    tests_run++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL reset_ctl: {rsp_valid,busy,req_ready} got %b expected 001",
               {rsp_valid, busy, req_ready});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0]   va [4] = '{8'hC5, 8'hF0, 8'h5A, 8'h0F};
    logic [W-1:0]   vb [4] = '{8'hA3, 8'h3C, 8'h96, 8'h55};
    logic [1:0]     vo [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
    logic [4*W-1:0] ve [4] = '{32'h81442218, 32'h0FC3CC33, 32'h00FF5A96, 32'h5FAFF5FA};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send_req(va[i], vb[i], vo[i]);
      tests_run++;
      if ({busy, req_ready} !== 2'b10) begin
        tests_failed++;
        $display("FAIL dir_accept[%0d]: {busy,req_ready} got %b expected 10", i, {busy, req_ready});
      end
      wait_rsp(lat);
      tests_run++;
      if (lat !== W) begin
        tests_failed++;
        $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, W);
      end
      tests_run++;
      if ({rsp_f1, rsp_f2, rsp_f3, rsp_f4} !== ve[i]) begin
        tests_failed++;
        $display("FAIL dir_result[%0d]: got %h expected %h", i, {rsp_f1, rsp_f2, rsp_f3, rsp_f4}, ve[i]);
      end
      release_rsp();
      tests_run++;
      if ({rsp_valid, busy, req_ready} !== 3'b001) begin
        tests_failed++;
        $display("FAIL dir_idle[%0d]: got %b expected 001", i, {rsp_valid, busy, req_ready});
      end
    end
  endtask

  task automatic test_stall();
    logic [4*W-1:0] exp1 = 32'h5FAFF5FA;
    logic [4*W-1:0] exp2;
    int lat;
    send_req(8'h0F, 8'h55, 2'b11);
    wait_rsp(lat);
    // Second request held on the bus during the stall.
    req_a = 8'h3C; req_b = 8'h99; req_op = 2'b01; req_valid = 1'b1;
    exp2 = model(8'h3C, 8'h99, 2'b01);
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if ({rsp_valid, req_ready, rsp_f1, rsp_f2, rsp_f3, rsp_f4} !== {2'b10, exp1}) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", c,
                 {rsp_valid, req_ready, rsp_f1, rsp_f2, rsp_f3, rsp_f4}, {2'b10, exp1});
      end
      tick();
    end
    release_rsp();
    tests_run++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL stall_release: got %b expected 001", {rsp_valid, busy, req_ready});
    end
    tick();
    req_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_second_accept: busy got %b expected 1", busy);
    end
    wait_rsp(lat);
    tests_run++;
    if ({rsp_f1, rsp_f2, rsp_f3, rsp_f4} !== exp2 || lat !== W) begin
      tests_failed++;
      $display("FAIL stall_second_result: got %h lat %0d expected %h lat %0d",
               {rsp_f1, rsp_f2, rsp_f3, rsp_f4}, lat, exp2, W);
    end
    release_rsp();
  endtask

  task automatic test_midrun_reset();
    int lat;
    send_req(8'hFF, 8'h0F, 2'b11);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if ({rsp_valid, busy, req_ready, rsp_f1, rsp_f2, rsp_f3, rsp_f4} !== {3'b001, {4*W{1'b0}}}) begin
      tests_failed++;
      $display("FAIL midrun_reset: got %h expected %h",
               {rsp_valid, busy, req_ready, rsp_f1, rsp_f2, rsp_f3, rsp_f4}, {3'b001, {4*W{1'b0}}});
    end
    send_req(8'hC5, 8'hA3, 2'b01);
    wait_rsp(lat);
    tests_run++;
    if ({rsp_f1, rsp_f2, rsp_f3, rsp_f4} !== 32'h81442218 || lat !== W) begin
      tests_failed++;
      $display("FAIL midrun_fresh: got %h lat %0d expected 81442218 lat %0d",
               {rsp_f1, rsp_f2, rsp_f3, rsp_f4}, lat, W);
    end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    logic [4*W-1:0] exp;
    logic [4*W-1:0] exp_q [$];
    logic           prev_busy;
    int             last_rise;
    int             rises;
    req_a = W'($urandom); req_b = W'($urandom); req_op = 2'($urandom);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    prev_busy = busy;
    last_rise = -1;
    rises = 0;
    for (int c = 0; c < 4 * (W + 2) + 2; c++) begin
      tick();
      if (busy && !prev_busy) begin
        exp_q.push_back(model(req_a, req_b, req_op));
        if (last_rise >= 0) begin
          tests_run++;
          if (c - last_rise !== W + 2) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d expected %0d", c - last_rise, W + 2);
          end
        end
        last_rise = c;
        rises++;
        req_a = W'($urandom); req_b = W'($urandom); req_op = 2'($urandom);
      end
      if (rsp_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : {4*W{1'bx}};
        tests_run++;
        if ({rsp_f1, rsp_f2, rsp_f3, rsp_f4} !== exp) begin
          tests_failed++;
          $display("FAIL b2b_result: got %h expected %h", {rsp_f1, rsp_f2, rsp_f3, rsp_f4}, exp);
        end
      end
      prev_busy = busy;
    end
    tests_run++;
    if (rises < 4) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d acceptances expected at least 4", rises);
    end
    req_valid = 1'b0;
    // Drain whatever is still in flight.
    for (int c = 0; c < W + 2; c++) tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0]   a, b;
    logic [1:0]     op;
    logic [4*W-1:0] exp;
    int             lat;
    int             stall;
    for (int n = 0; n < 25; n++) begin
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      exp = model(a, b, op);
      send_req(a, b, op);
      wait_rsp(lat);
      tests_run++;
      if ({rsp_f1, rsp_f2, rsp_f3, rsp_f4} !== exp || lat !== W) begin
        tests_failed++;
        $display("FAIL rand_result[%0d]: op %b a %h b %h got %h lat %0d expected %h lat %0d",
                 n, op, a, b, {rsp_f1, rsp_f2, rsp_f3, rsp_f4}, lat, exp, W);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) tick();
      tests_run++;
      if ({rsp_valid, rsp_f1, rsp_f2, rsp_f3, rsp_f4} !== {1'b1, exp}) begin
        tests_failed++;
        $display("FAIL rand_hold[%0d]: got %h expected %h", n,
                 {rsp_valid, rsp_f1, rsp_f2, rsp_f3, rsp_f4}, {1'b1, exp});
      end
      release_rsp();
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = 2'b00;
    #2;
    test_reset();
    test_directed();
    test_stall();
    test_midrun_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
